// File: rtl/axis_gate_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// axis_gate_scheduler_pkg
// Shared definitions for the time-triggered gate command scheduler:
//   - FSM state encoding
//   - bit positions of the fields inside a 192-bit command word
//   - tick counter and late counter widths
//   - the unsigned "late" comparison used at command acceptance
// No ports (package).
// -----------------------------------------------------------------------------
package axis_gate_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam int CMD_W      = 192;
    localparam int GATE_W     = 128;
    localparam int TICK_W     = 64;
    localparam int LATE_CNT_W = 32;

    // Command word layout
    localparam int START_LSB  = 128;
    localparam int START_MSB  = 191;
    localparam int WIDTH_LSB  = 0;
    localparam int WIDTH_MSB  = 63;
    localparam int POFF_LSB   = 64;
    localparam int POFF_MSB   = 95;
    localparam int LEVEL_LSB  = 96;
    localparam int LEVEL_MSB  = 111;

    // A command is late when its start tick is strictly behind the timer.
    // Start equal to the timer counts as on time.
    function automatic logic is_late(input logic [TICK_W-1:0] start,
                                     input logic [TICK_W-1:0] now);
        return (start < now);
    endfunction

endpackage

// File: rtl/axis_gate_scheduler_timer.sv
// -----------------------------------------------------------------------------
// axis_gate_scheduler_timer
// Free-running 64-bit tick counter. Clear has priority over run; the counter
// wraps modulo 2^64 with no special handling.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous active-high reset (counter -> 0)
//   run_i    in   increment enable
//   clear_i  in   synchronous clear, overrides run_i
//   timer_o  out  current counter value (registered)
// -----------------------------------------------------------------------------
module axis_gate_scheduler_timer
    import axis_gate_scheduler_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              clear_i,
    output logic [TICK_W-1:0] timer_o
);

    logic [TICK_W-1:0] timer_q;
    logic [TICK_W-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (run_i) begin
            timer_d = timer_q + {{(TICK_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_o = timer_q;

endmodule

// File: rtl/axis_gate_scheduler.sv
// -----------------------------------------------------------------------------
// axis_gate_scheduler
// Time-triggered front end for the gate controller. A timestamped command is
// accepted on the AXI4-Stream slave, held until the tick counter reaches its
// start tick, then its 128-bit gate word is offered on the AXI4-Stream master.
// Commands arriving after their start tick are counted (saturating) and either
// forwarded at once (LATE_DROP=0) or discarded (LATE_DROP=1). One command deep.
//
// Handshake: a beat transfers on a rising edge where both tvalid and tready are
// high. tvalid, once raised, stays high with tdata stable until that transfer;
// a source never waits for tready before asserting tvalid.
//
// Ports:
//   aclk           in   clock, rising edge
//   areset         in   synchronous active-high reset
//   cfg_run        in   tick counter increments while high
//   cfg_clear      in   synchronous tick counter clear, beats cfg_run
//   s_axis_tready  out  command accept (high in IDLE)
//   s_axis_tdata   in   [191:128] start tick, [127:0] gate word
//   s_axis_tvalid  in   command valid
//   m_axis_tready  in   gate controller accept
//   m_axis_tdata   out  latched gate word
//   m_axis_tvalid  out  gate word valid (high in SEND)
//   timer          out  current tick counter
//   late_cnt       out  saturating count of late commands
//   busy           out  high in WAIT or SEND
// All outputs come straight from registers or decode of registered state.
// -----------------------------------------------------------------------------
module axis_gate_scheduler
    import axis_gate_scheduler_pkg::*;
#(
    parameter bit LATE_DROP = 1'b0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cfg_run,
    input  logic                  cfg_clear,
    output logic                  s_axis_tready,
    input  logic [CMD_W-1:0]      s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [GATE_W-1:0]     m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic [TICK_W-1:0]     timer,
    output logic [LATE_CNT_W-1:0] late_cnt,
    output logic                  busy
);

    state_e                  state_q, state_d;
    logic [TICK_W-1:0]       start_q, start_d;
    logic [GATE_W-1:0]       gate_q,  gate_d;
    logic [LATE_CNT_W-1:0]   late_q,  late_d;
    logic [TICK_W-1:0]       timer_w;
    logic [TICK_W-1:0]       cmd_start;

    axis_gate_scheduler_timer u_timer (
        .clk_i   (aclk),
        .rst_i   (areset),
        .run_i   (cfg_run),
        .clear_i (cfg_clear),
        .timer_o (timer_w)
    );

    assign cmd_start = s_axis_tdata[START_MSB:START_LSB];

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        gate_d  = gate_q;
        late_d  = late_q;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    if (is_late(cmd_start, timer_w)) begin
                        if (late_q != {LATE_CNT_W{1'b1}}) begin
                            late_d = late_q + {{(LATE_CNT_W-1){1'b0}}, 1'b1};
                        end
                        // A dropped command leaves the previous gate word on
                        // m_axis_tdata; tvalid stays low so nothing is offered.
                        if (!LATE_DROP) begin
                            start_d = cmd_start;
                            gate_d  = s_axis_tdata[GATE_W-1:0];
                            state_d = ST_SEND;
                        end
                    end else begin
                        start_d = cmd_start;
                        gate_d  = s_axis_tdata[GATE_W-1:0];
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Compared against the registered timer, so SEND begins one
                // tick after the timer equals start.
                if (!is_late(timer_w, start_q)) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            gate_q  <= '0;
            late_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            gate_q  <= gate_d;
            late_q  <= late_d;
        end
    end

    assign s_axis_tready = (state_q == ST_IDLE);
    assign m_axis_tvalid = (state_q == ST_SEND);
    assign busy          = (state_q == ST_WAIT) || (state_q == ST_SEND);
    assign m_axis_tdata  = gate_q;
    assign late_cnt      = late_q;
    assign timer         = timer_w;

endmodule

// File: tb/tb_axis_gate_scheduler.sv
module tb_axis_gate_scheduler;
    import axis_gate_scheduler_pkg::*;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic          areset    = 1'b1;
    logic          cfg_run   = 1'b0;
    logic          cfg_clear = 1'b0;
    logic [191:0]  s_tdata   = '0;

    logic          s_tvalid0 = 1'b0, s_tready0;
    logic          m_tready0 = 1'b1, m_tvalid0;
    logic [127:0]  m_tdata0;
    logic [63:0]   timer0;
    logic [31:0]   late0;
    logic          busy0;

    logic          s_tvalid1 = 1'b0, s_tready1;
    logic          m_tready1 = 1'b1, m_tvalid1;
    logic [127:0]  m_tdata1;
    logic [63:0]   timer1;
    logic [31:0]   late1;
    logic          busy1;

    axis_gate_scheduler #(.LATE_DROP(1'b0)) dut0 (
        .aclk(aclk), .areset(areset), .cfg_run(cfg_run), .cfg_clear(cfg_clear),
        .s_axis_tready(s_tready0), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid0),
        .m_axis_tready(m_tready0), .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0),
        .timer(timer0), .late_cnt(late0), .busy(busy0)
    );

    axis_gate_scheduler #(.LATE_DROP(1'b1)) dut1 (
        .aclk(aclk), .areset(areset), .cfg_run(cfg_run), .cfg_clear(cfg_clear),
        .s_axis_tready(s_tready1), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid1),
        .m_axis_tready(m_tready1), .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1),
        .timer(timer1), .late_cnt(late1), .busy(busy1)
    );

    int errors = 0;
    int checks = 0;

    // Reference tick counter driven from the same controls
    logic [63:0] model_timer = '0;
    always @(posedge aclk) begin
        if (areset || cfg_clear) model_timer <= '0;
        else if (cfg_run)        model_timer <= model_timer + 64'd1;
    end

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (!areset && m_tvalid0 && m_tready0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected none", m_tdata0);
            end else begin
                check("sb_data", m_tdata0, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [127:0] mk_gate(input logic [63:0] w, input logic [31:0] p,
                                             input logic [15:0] l);
        logic [127:0] g;
        g = '0;
        g[WIDTH_MSB:WIDTH_LSB] = w;
        g[POFF_MSB:POFF_LSB]   = p;
        g[LEVEL_MSB:LEVEL_LSB] = l;
        return g;
    endfunction

    function automatic logic [191:0] mk_cmd(input logic [63:0] start, input logic [127:0] gate);
        logic [191:0] c;
        c = '0;
        c[START_MSB:START_LSB] = start;
        c[GATE_W-1:0]          = gate;
        return c;
    endfunction

    task automatic wait_idle0();
        int n;
        n = 0;
        while (!s_tready0 && n < 100) begin
            tick();
            n++;
        end
        if (!s_tready0) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic wait_timer(input logic [63:0] target);
        int n;
        n = 0;
        while (model_timer != target && n < 500) begin
            tick();
            n++;
        end
        if (model_timer != target) check("wait_timer_timeout", model_timer, target);
    endtask

    // Present one command for one cycle; caller guarantees s_tready0 is high.
    task automatic send0(input logic [63:0] start, input logic [127:0] gate, input bit fwd);
        s_tdata   = mk_cmd(start, gate);
        s_tvalid0 = 1'b1;
        tick();
        s_tvalid0 = 1'b0;
        if (fwd) exp_q.push_back(gate);
    endtask

    // Cycles from the handshake edge until m_tvalid0 is seen (1 = next cycle).
    task automatic wait_tvalid0(output int lat);
        lat = 1;
        while (!m_tvalid0 && lat < 200) begin
            tick();
            lat++;
        end
        if (!m_tvalid0) check("tvalid_timeout", 0, 1);
    endtask

    typedef struct {
        int delta;     // start - timer in the handshake cycle
        int exp_lat;   // handshake -> m_tvalid cycles
        bit exp_late;
    } vec_t;

    initial begin
        vec_t         vecs[6];
        int           lat;
        int           exp_late;
        int           bad;
        longint       d64;
        logic [63:0]  st;
        logic [127:0] g;
        logic [63:0]  hold_t;

        vecs[0] = '{-50, 1, 1'b1};
        vecs[1] = '{ -1, 1, 1'b1};
        vecs[2] = '{  0, 2, 1'b0};
        vecs[3] = '{  1, 2, 1'b0};
        vecs[4] = '{  5, 6, 1'b0};
        vecs[5] = '{ 12, 13, 1'b0};
        exp_late = 0;

        // ---- reset state ----
        repeat (3) tick();
        areset = 1'b0;
        check("rst_s_tready", s_tready0, 1);
        check("rst_m_tvalid", m_tvalid0, 0);
        check("rst_m_tdata", m_tdata0, 0);
        check("rst_busy", busy0, 0);
        check("rst_timer", timer0, 0);
        check("rst_late", late0, 0);
        check("rst_m_tvalid_drop", m_tvalid1, 0);

        // ---- timer counts under cfg_run ----
        cfg_run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("timer_count", timer0, k + 1);
        end

        // ---- on-time command: timer=10, start=20 ----
        wait_timer(64'd10);
        g = mk_gate(64'd5, 32'd0, 16'h1234);
        send0(64'd20, g, 1'b1);
        check("ontime_busy", busy0, 1);
        check("ontime_busy_timer", timer0, 11);
        check("ontime_s_tready", s_tready0, 0);
        wait_tvalid0(lat);
        check("ontime_tvalid_timer", timer0, 21);
        check("ontime_tdata", m_tdata0, g);
        check("ontime_latency", lat, 11);
        tick();

        // ---- table: late / boundary / on-time latencies ----
        wait_timer(64'd100);
        for (int i = 0; i < 6; i++) begin
            wait_idle0();
            d64 = vecs[i].delta;
            st  = model_timer + d64;
            g   = mk_gate(64'(i + 1), 32'(i * 3 + 7), 16'(16'hA000 + i));
            send0(st, g, 1'b1);
            if (vecs[i].exp_late) exp_late++;
            check("vec_late_cnt", late0, exp_late);
            wait_tvalid0(lat);
            check("vec_latency", lat, vecs[i].exp_lat);
            check("vec_tdata", m_tdata0, g);
            tick();
            check("vec_idle_after", s_tready0, 1);
        end

        // ---- backpressure in SEND, with a cfg_clear in the middle ----
        wait_idle0();
        m_tready0 = 1'b0;
        g = mk_gate(64'hDEAD_BEEF_0000_0001, 32'h55, 16'h7);
        send0(model_timer, g, 1'b1);
        wait_tvalid0(lat);
        for (int k = 0; k < 7; k++) begin
            cfg_clear = (k == 3);
            check("bp_tvalid", m_tvalid0, 1);
            check("bp_tdata", m_tdata0, g);
            check("bp_s_tready", s_tready0, 0);
            tick();
        end
        cfg_clear = 1'b0;
        check("bp_timer_model", timer0, model_timer);
        m_tready0 = 1'b1;
        tick();
        check("bp_after_tvalid", m_tvalid0, 0);
        check("bp_after_s_tready", s_tready0, 1);
        check("bp_after_busy", busy0, 0);

        // ---- cfg_clear during WAIT: start=30, clear at timer=15 ----
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        wait_timer(64'd5);
        g = mk_gate(64'd30, 32'd15, 16'h0BEE);
        send0(64'd30, g, 1'b1);
        wait_timer(64'd15);
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        check("clr_timer_zero", timer0, 0);
        check("clr_busy", busy0, 1);
        wait_tvalid0(lat);
        check("clr_tvalid_timer", timer0, 31);
        check("clr_tdata", m_tdata0, g);
        tick();

        // ---- stalled timer in WAIT ----
        wait_idle0();
        st = model_timer + 64'd3;
        g  = mk_gate(64'd77, 32'd1, 16'h0001);
        send0(st, g, 1'b1);
        cfg_run = 1'b0;
        hold_t  = model_timer;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (m_tvalid0 || !busy0 || s_tready0) bad++;
        end
        check("stall_hold_bad_cycles", bad, 0);
        check("stall_timer_frozen", timer0, hold_t);
        cfg_run = 1'b1;
        wait_tvalid0(lat);
        check("stall_release_timer", timer0, st + 64'd1);
        check("stall_tdata", m_tdata0, g);
        tick();

        // ---- LATE_DROP=1: timer=100, start=50 ----
        wait_timer(64'd100);
        g = mk_gate(64'd9, 32'd9, 16'h0999);
        s_tdata   = mk_cmd(64'd50, g);
        s_tvalid1 = 1'b1;
        tick();
        s_tvalid1 = 1'b0;
        check("drop_late_cnt", late1, 1);
        check("drop_s_tready", s_tready1, 1);
        check("drop_busy", busy1, 0);
        check("drop_tvalid", m_tvalid1, 0);
        tick();
        check("drop_tvalid_next", m_tvalid1, 0);

        // start equal to timer is on time even with LATE_DROP=1
        g = mk_gate(64'd10, 32'd20, 16'h0030);
        s_tdata   = mk_cmd(model_timer, g);
        s_tvalid1 = 1'b1;
        tick();
        s_tvalid1 = 1'b0;
        check("eq_not_late", late1, 1);
        check("eq_busy", busy1, 1);
        check("eq_wait_no_tvalid", m_tvalid1, 0);
        tick();
        check("eq_tvalid", m_tvalid1, 1);
        check("eq_tdata", m_tdata1, g);
        tick();
        check("eq_idle_after", s_tready1, 1);

        // ---- reset in the middle of SEND ----
        wait_idle0();
        m_tready0 = 1'b0;
        g = mk_gate(64'd1, 32'd2, 16'h0003);
        send0(model_timer - 64'd4, g, 1'b0);
        wait_tvalid0(lat);
        check("midrst_pre_tvalid", m_tvalid0, 1);
        check("midrst_pre_late", late0, exp_late + 1);
        areset = 1'b1;
        tick();
        check("midrst_tvalid", m_tvalid0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_s_tready", s_tready0, 1);
        check("midrst_timer", timer0, 0);
        check("midrst_late", late0, 0);
        check("midrst_tdata", m_tdata0, 0);
        areset    = 1'b0;
        m_tready0 = 1'b1;
        tick();
        check("midrst_after_tvalid", m_tvalid0, 0);

        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_gate_scheduler.md
# axis_gate_scheduler

- Time-triggered front end for the gate controller.
- Accepts timestamped gate commands on an AXI4-Stream slave and holds each one until a free-running 64-bit tick counter reaches its start time.
- Then forwards the 128-bit gate word on an AXI4-Stream master to the gate controller's slave input.
- Counts commands that arrive after their start time, and optionally drops them.

## Interface
Parameters:
- LATE_DROP, 0: 0 = late commands are forwarded immediately; 1 = late commands are discarded.

Ports:
- aclk  in  1  clock; all logic on its rising edge.
- areset  in  1  reset; synchronous, active-high.
- cfg_run  in  1  tick counter increments while high.
- cfg_clear  in  1  synchronous tick-counter clear; has priority over cfg_run.
- s_axis_tready  out  1  command accept.
- s_axis_tdata  in  192  command word:
  - [191:128] start tick, unsigned.
  - [127:0] gate word, forwarded untouched: width [63:0], poff [95:64], level [111:96].
- s_axis_tvalid  in  1  command valid.
- m_axis_tready  in  1  gate controller accept.
- m_axis_tdata  out  128  gate word.
- m_axis_tvalid  out  1  gate word valid.
- timer  out  64  current tick counter.
- late_cnt  out  32  saturating count of late commands.
- busy  out  1  high in WAIT or SEND.

## Operation
- Tick counter:
  - cfg_clear → 0 next cycle.
  - Otherwise, if cfg_run → +1, wrapping modulo 2^64.
  - Otherwise holds.
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - s_axis_tready = 1.
  - On s_axis_tvalid, latch start and gate word (handshake).
  - Late means start < timer, unsigned, evaluated in the handshake cycle.
  - On time: next state WAIT.
  - Late with LATE_DROP=0: next state SEND; late_cnt += 1.
  - Late with LATE_DROP=1: stay in IDLE; discard the word; late_cnt += 1.
- WAIT:
  - s_axis_tready = 0.
  - When timer >= start (unsigned), next state SEND.
  - If cfg_clear or a stalled timer prevents the condition, the FSM waits indefinitely.
- SEND:
  - m_axis_tvalid = 1.
  - m_axis_tdata holds the latched gate word, stable until handshake.
  - On m_axis_tready, next state IDLE.
- Queue depth is one command: no new command is accepted until the previous one is handed off.
- late_cnt saturates at 0xFFFFFFFF.
- late_cnt is cleared only by areset; cfg_clear does not affect it.

## Timing
- Reset values:
  - state IDLE.
  - timer 0.
  - late_cnt 0.
  - m_axis_tdata 0.
  - m_axis_tvalid 0.
  - busy 0.
  - s_axis_tready 1 from the first cycle after reset.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Trigger latency:
  - WAIT→SEND transition happens on the edge following the cycle where the timer register equals start.
  - m_axis_tvalid therefore rises in the cycle where timer = start+1, with cfg_run continuously high.
- Accept → earliest m_axis_tvalid:
  - Late command with LATE_DROP=0: 1 cycle.
  - On-time command: ≥ 2 cycles.
- Start equal to timer in the handshake cycle is on time, not late:
  - WAIT for 1 cycle, then SEND.
- Handshake rule: m_axis_tvalid is never withdrawn before m_axis_tready, including across cfg_clear.
- Simultaneous cfg_clear and run: clear wins.
- cfg_clear during WAIT: the comparison uses the cleared value from the next cycle on.
- areset mid-operation: the pending command is discarded, m_axis_tvalid drops next cycle, and no partial transfer is counted.
- Timer wrap from 2^64−1 to 0: no special handling. A start behind the wrapped timer simply waits until it is reached again.

## Structure
- Shared package: state encoding (IDLE, WAIT, SEND), command field bit positions (start, width, poff, level), late_cnt width.
- One natural sub-module: axis_gate_scheduler_timer, holding the 64-bit counter with run/clear. The FSM, latching and late counter stay in the top.

## Test plan
- Reset then idle: s_axis_tready=1, m_axis_tvalid=0, timer counts 0,1,2… under cfg_run=1.
- On-time command:
  - Stimulus: timer=10, send start=20, width=5, level=0x1234.
  - Response: m_axis_tvalid rises at timer=21 with m_axis_tdata = command[127:0]; busy high from timer=11.
- Backpressure: hold m_axis_tready=0 for 7 cycles in SEND → tvalid and tdata stable, s_axis_tready=0 throughout; IDLE the cycle after the accept.
- Late command:
  - Stimulus: timer=100, start=50.
  - LATE_DROP=0: late_cnt=1 and tvalid next cycle.
  - LATE_DROP=1: late_cnt=1, no output, s_axis_tready stays 1.
  - Boundary: start=timer is not late.
- Clear/stall in WAIT:
  - Stimulus: start=30, cfg_clear at timer=15.
  - Response: timer restarts at 0, tvalid at timer=31.
  - With cfg_run=0 the FSM holds WAIT indefinitely.
- Reset mid-SEND with tvalid=1: next cycle tvalid=0, state IDLE, timer=0, late_cnt=0.
